// File: rtl/reg_bus_sequencer_pkg.sv
// Shared types for the register bus sequencer: FSM states and latched operation codes.
package reg_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    ACCESS,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    READ,
    WRITE,
    PRESET
  } op_e;

endpackage

// File: rtl/reg_bus_sequencer_if.sv
// Requester and register-bus signal bundle; slave = sequencer side, master = requesters/registers.
// The preset signals exist only when REG_BUS_PRESET_EN is defined.
interface reg_bus_sequencer_if #(
  parameter int NrOfRequesters = 2,
  parameter int NrOfRegs       = 4,
  parameter int NrOfBits       = 8,
  parameter int AddrBits       = 2
);

  logic [NrOfRequesters-1:0]          Req;
  logic [NrOfRequesters-1:0]          ReqWrite;
  logic [NrOfRequesters*AddrBits-1:0] ReqAddr;
  logic [NrOfRequesters*NrOfBits-1:0] ReqData;
  logic [NrOfRequesters-1:0]          Grant;
  logic [NrOfRequesters-1:0]          Ack;
  logic [NrOfBits-1:0]                RdData;
  logic [NrOfBits-1:0]                BusWrData;
  logic [NrOfBits-1:0]                BusRdData;
  logic [NrOfRegs-1:0]                RegCs;
  logic [NrOfRegs-1:0]                RegClockEnable;
  logic                               Tick;
`ifdef REG_BUS_PRESET_EN
  logic [NrOfRequesters-1:0]          ReqPreset;
  logic [NrOfRegs-1:0]                RegPre;

  modport slave (
    input  Req, ReqWrite, ReqAddr, ReqData, ReqPreset, BusRdData,
    output Grant, Ack, RdData, BusWrData, RegCs, RegClockEnable, Tick, RegPre
  );

  modport master (
    output Req, ReqWrite, ReqAddr, ReqData, ReqPreset, BusRdData,
    input  Grant, Ack, RdData, BusWrData, RegCs, RegClockEnable, Tick, RegPre
  );
`else
  modport slave (
    input  Req, ReqWrite, ReqAddr, ReqData, BusRdData,
    output Grant, Ack, RdData, BusWrData, RegCs, RegClockEnable, Tick
  );

  modport master (
    output Req, ReqWrite, ReqAddr, ReqData, BusRdData,
    input  Grant, Ack, RdData, BusWrData, RegCs, RegClockEnable, Tick
  );
`endif

endinterface

// File: rtl/reg_bus_sequencer_rr_arbiter.sv
// Round-robin picker: searches from ptr_i+1 upward (wrapping) and returns a one-hot grant.
module rr_arbiter #(
  parameter int N    = 2,
  parameter int IdxW = 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    grant_o
);

  logic found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req_i[i] && (i == (int'(ptr_i) + k) % N)) begin
          grant_o[i] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/reg_bus_sequencer.sv
// Register bus sequencer: arbitrates requesters and runs one IDLE-GRANT-ACCESS-DONE cycle per access.
// Optional preset path enabled by defining REG_BUS_PRESET_EN.
module reg_bus_sequencer
  import reg_bus_pkg::*;
#(
  parameter int NrOfRequesters = 2,
  parameter int NrOfRegs       = 4,
  parameter int NrOfBits       = 8,
  parameter int AddrBits       = 2
) (
  input  logic                 Clock,
  input  logic                 Reset,
  reg_bus_sequencer_if.slave   bus
);

  localparam int IdxW = (NrOfRequesters > 1) ? $clog2(NrOfRequesters) : 1;

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  logic [IdxW-1:0]       ptr_q, ptr_d;
  logic [IdxW-1:0]       owner_q, owner_d;
  logic [AddrBits-1:0]   addr_q, addr_d;
  logic [NrOfBits-1:0]   data_q, data_d;
  logic [NrOfBits-1:0]   rd_q, rd_d;
  logic [NrOfBits-1:0]   wr_q, wr_d;

  logic [NrOfRequesters-1:0] win_oh;
  logic [NrOfRequesters-1:0] owner_oh;
  logic [IdxW-1:0]           win_idx;
  logic [AddrBits-1:0]       win_addr;
  logic [NrOfBits-1:0]       win_data;
  op_e                       win_op;
  logic                      addr_ok;
  logic                      in_access;

  rr_arbiter #(
    .N    (NrOfRequesters),
    .IdxW (IdxW)
  ) u_arb (
    .req_i   (bus.Req),
    .ptr_i   (ptr_q),
    .grant_o (win_oh)
  );

  always_comb begin
    win_idx  = '0;
    win_addr = '0;
    win_data = '0;
    win_op   = READ;
    for (int i = 0; i < NrOfRequesters; i++) begin
      if (win_oh[i]) begin
        win_idx  = IdxW'(i);
        win_addr = bus.ReqAddr[i*AddrBits +: AddrBits];
        win_data = bus.ReqData[i*NrOfBits +: NrOfBits];
`ifdef REG_BUS_PRESET_EN
        if (bus.ReqPreset[i]) win_op = PRESET;
        else                  win_op = bus.ReqWrite[i] ? WRITE : READ;
`else
        win_op   = bus.ReqWrite[i] ? WRITE : READ;
`endif
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NrOfRequesters; i++) owner_oh[i] = (owner_q == IdxW'(i));
  end

  assign addr_ok   = (int'(addr_q) < NrOfRegs);
  assign in_access = (state_q == ACCESS);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    unique case (state_q)
      IDLE: begin
        if (|bus.Req) begin
          state_d = GRANT;
          owner_d = win_idx;
          op_d    = win_op;
          addr_d  = win_addr;
          data_d  = win_data;
        end
      end
      GRANT: begin
        state_d = ACCESS;
        if (op_q == WRITE) wr_d = data_q;
      end
      ACCESS: begin
        state_d = DONE;
        // Unmapped addresses leave the Q bus undriven, so return zero instead.
        if (op_q == READ) rd_d = addr_ok ? bus.BusRdData : '0;
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = owner_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // Load strobes and Ack are qualified by Reset so an abandoned access never loads a register.
  always_comb begin
    bus.Grant          = (state_q != IDLE) ? owner_oh : '0;
    bus.Ack            = (state_q == DONE && Reset) ? owner_oh : '0;
    bus.RdData         = rd_q;
    bus.BusWrData      = wr_q;
    bus.Tick           = in_access && (op_q == WRITE) && Reset;
    bus.RegCs          = '1;
    bus.RegClockEnable = '0;
`ifdef REG_BUS_PRESET_EN
    bus.RegPre         = '0;
`endif
    for (int i = 0; i < NrOfRegs; i++) begin
      if (in_access && int'(addr_q) == i) begin
        if (op_q == READ)  bus.RegCs[i]          = 1'b0;
        if (op_q == WRITE) bus.RegClockEnable[i] = Reset;
`ifdef REG_BUS_PRESET_EN
        if (op_q == PRESET) bus.RegPre[i]        = Reset;
`endif
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= IDLE;
      op_q    <= READ;
      ptr_q   <= IdxW'(NrOfRequesters - 1);
      owner_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  always_ff @(posedge Clock) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_reg_bus_sequencer.sv
// Bench for reg_bus_sequencer: transaction-level model with randomized requests and a register file model.
module tb_reg_bus_sequencer;

  localparam int NREQ  = 2;
  localparam int NREGS = 3;
  localparam int NB    = 8;
  localparam int AB    = 2;
  localparam int AW    = NREQ * AB;
  localparam int DW    = NREQ * NB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_bus_sequencer_if #(
    .NrOfRequesters (NREQ),
    .NrOfRegs       (NREGS),
    .NrOfBits       (NB),
    .AddrBits       (AB)
  ) bus ();

  reg_bus_sequencer #(
    .NrOfRequesters (NREQ),
    .NrOfRegs       (NREGS),
    .NrOfBits       (NB),
    .AddrBits       (AB)
  ) dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [NB-1:0] phys [NREGS];
  logic [NB-1:0] noise = 8'h99;
  logic          init_regs = 1'b0;

  int            ptr_m;
  logic [NB-1:0] mem_m [NREGS];
  logic [NB-1:0] rd_m;
  logic [NB-1:0] bw_m;

  function automatic logic [NB-1:0] init_val(input int i);
    case (i)
      0:       return 8'h11;
      1:       return 8'h3C;
      default: return 8'h5A;
    endcase
  endfunction

  // Physical registers sitting on the shared bus.
  always @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (init_regs) phys[i] <= init_val(i);
      else if (bus.Tick && bus.RegClockEnable[i]) phys[i] <= bus.BusWrData;
`ifdef REG_BUS_PRESET_EN
      else if (bus.RegPre[i]) phys[i] <= '1;
`endif
    end
  end

  always_comb begin
    bus.BusRdData = noise;
    for (int i = 0; i < NREGS; i++) if (!bus.RegCs[i]) bus.BusRdData = phys[i];
  end

  function automatic int pick(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (last + k) % NREQ;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    ptr_m = NREQ - 1;
    rd_m  = '0;
    bw_m  = '0;
    for (int i = 0; i < NREGS; i++) mem_m[i] = init_val(i);
  endtask

  task automatic clear_inputs();
    bus.Req      = '0;
    bus.ReqWrite = '0;
    bus.ReqAddr  = '0;
    bus.ReqData  = '0;
`ifdef REG_BUS_PRESET_EN
    bus.ReqPreset = '0;
`endif
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    clear_inputs();
    init_regs = 1'b1;
    step();
    init_regs = 1'b0;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Runs one transaction from an IDLE cycle and checks every cycle through the following IDLE.
  task automatic run_txn(input logic [NREQ-1:0] r, input logic [NREQ-1:0] w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input bit drop, input string tag);
    int win;
    logic wr;
    logic [AB-1:0] ad;
    logic [NB-1:0] dt;
    logic [NREQ-1:0] exp_g;
    logic [NREGS-1:0] exp_cs, exp_ce;
    bus.Req = r; bus.ReqWrite = w; bus.ReqAddr = a; bus.ReqData = d;
    noise = NB'($urandom) | NB'(1);
    win = pick(r, ptr_m);
    if (win < 0) begin
      step();
      checks++;
      if (bus.Grant !== '0) begin
        errors++; $display("FAIL %s idle_grant: got %b want 0", tag, bus.Grant);
      end
      return;
    end
    wr = w[win]; ad = a[win*AB +: AB]; dt = d[win*NB +: NB];
    exp_g = NREQ'(1) << win;
    step();
    checks++;
    if (bus.Grant !== exp_g || bus.Ack !== '0) begin
      errors++; $display("FAIL %s grant_cycle: got g=%b a=%b want g=%b a=0", tag, bus.Grant, bus.Ack, exp_g);
    end
    // Latched values must survive the requester changing or dropping its inputs.
    bus.Req      = drop ? '0 : (r | NREQ'($urandom));
    bus.ReqWrite = NREQ'($urandom);
    bus.ReqAddr  = AW'($urandom);
    bus.ReqData  = DW'($urandom);
    step();
    exp_cs = '1; exp_ce = '0;
    if (int'(ad) < NREGS) begin
      if (wr) exp_ce[ad] = 1'b1;
      else    exp_cs[ad] = 1'b0;
    end
    if (wr) bw_m = dt;
    checks++;
    if (bus.RegCs !== exp_cs || bus.RegClockEnable !== exp_ce || bus.Tick !== wr) begin
      errors++; $display("FAIL %s access_strobes: got cs=%b ce=%b tick=%b want cs=%b ce=%b tick=%b",
                         tag, bus.RegCs, bus.RegClockEnable, bus.Tick, exp_cs, exp_ce, wr);
    end
    checks++;
    if (bus.BusWrData !== bw_m || bus.Grant !== exp_g || bus.Ack !== '0) begin
      errors++; $display("FAIL %s access_data: got d=%h g=%b a=%b want d=%h g=%b a=0",
                         tag, bus.BusWrData, bus.Grant, bus.Ack, bw_m, exp_g);
    end
    step();
    if (!wr) rd_m = (int'(ad) < NREGS) ? mem_m[ad] : '0;
    else if (int'(ad) < NREGS) mem_m[ad] = dt;
    ptr_m = win;
    checks++;
    if (bus.Ack !== exp_g || bus.Grant !== exp_g || bus.RdData !== rd_m) begin
      errors++; $display("FAIL %s done: got a=%b g=%b rd=%h want a=%b g=%b rd=%h",
                         tag, bus.Ack, bus.Grant, bus.RdData, exp_g, exp_g, rd_m);
    end
    checks++;
    if (bus.RegCs !== '1 || bus.Tick !== 1'b0 || bus.RegClockEnable !== '0) begin
      errors++; $display("FAIL %s done_strobes: got cs=%b tick=%b ce=%b want all-idle",
                         tag, bus.RegCs, bus.Tick, bus.RegClockEnable);
    end
    bus.Req = '0;
    step();
    checks++;
    if (bus.Grant !== '0 || bus.Ack !== '0 || bus.RdData !== rd_m || bus.BusWrData !== bw_m) begin
      errors++; $display("FAIL %s idle_after: got g=%b a=%b rd=%h d=%h want g=0 a=0 rd=%h d=%h",
                         tag, bus.Grant, bus.Ack, bus.RdData, bus.BusWrData, rd_m, bw_m);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.Req = '1; bus.ReqWrite = '1; bus.ReqAddr = '0; bus.ReqData = '1;
`ifdef REG_BUS_PRESET_EN
    bus.ReqPreset = '0;
`endif
    init_regs = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (bus.Grant !== '0 || bus.Ack !== '0 || bus.Tick !== 1'b0) begin
        errors++; $display("FAIL reset_ctrl: got g=%b a=%b tick=%b want 0", bus.Grant, bus.Ack, bus.Tick);
      end
      checks++;
      if (bus.RegCs !== '1 || bus.RegClockEnable !== '0) begin
        errors++; $display("FAIL reset_regs: got cs=%b ce=%b want cs=all1 ce=0", bus.RegCs, bus.RegClockEnable);
      end
      checks++;
      if (bus.RdData !== '0 || bus.BusWrData !== '0) begin
        errors++; $display("FAIL reset_data: got rd=%h d=%h want 0", bus.RdData, bus.BusWrData);
      end
    end
    init_regs = 1'b0;
    clear_inputs();
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_write_basic();
    run_txn(2'b01, 2'b01, {2'd0, 2'd2}, {8'h00, 8'hA5}, 1'b0, "write_a5");
  endtask

  task automatic test_read_basic();
    run_txn(2'b01, 2'b00, {2'd0, 2'd1}, '0, 1'b0, "read_3c");
    checks++;
    if (rd_m !== 8'h3C || bus.RdData !== 8'h3C) begin
      errors++; $display("FAIL read_value: got %h want 3c", bus.RdData);
    end
    run_txn(2'b10, 2'b00, {2'd2, 2'd0}, '0, 1'b0, "read_back_a5");
  endtask

  task automatic test_out_of_range();
    run_txn(2'b01, 2'b00, {2'd0, 2'd3}, '0, 1'b0, "read_oob");
    run_txn(2'b10, 2'b10, {2'd3, 2'd0}, {8'h77, 8'h00}, 1'b0, "write_oob");
  endtask

  task automatic test_drop_req();
    run_txn(2'b10, 2'b10, {2'd1, 2'd0}, {8'hC3, 8'h00}, 1'b1, "drop_write");
    run_txn(2'b11, 2'b00, {2'd1, 2'd1}, '0, 1'b1, "drop_read");
  endtask

  task automatic test_back_to_back();
    logic [NREQ-1:0] exp_g, exp_a;
    rst_n = 1'b0;
    bus.Req = '1; bus.ReqWrite = '0; bus.ReqAddr = '0; bus.ReqData = '0;
    init_regs = 1'b1;
    step();
    init_regs = 1'b0;
    rst_n = 1'b1;
    model_reset();
    step();
    for (int c = 0; c < 12; c++) begin
      exp_g = (c % 4 == 3) ? '0 : NREQ'(1) << ((c / 4 + ptr_m + 1) % NREQ);
      exp_a = (c % 4 == 2) ? exp_g : '0;
      checks++;
      if (bus.Grant !== exp_g || bus.Ack !== exp_a) begin
        errors++; $display("FAIL b2b_cycle%0d: got g=%b a=%b want g=%b a=%b", c, bus.Grant, bus.Ack, exp_g, exp_a);
      end
      step();
    end
    reset_dut();
  endtask

  task automatic test_reset_mid();
    bus.Req = 2'b01; bus.ReqWrite = 2'b01; bus.ReqAddr = {2'd0, 2'd1}; bus.ReqData = {8'h00, 8'h77};
    step();
    bus.Req = '0;
    step();
    checks++;
    if (bus.Tick !== 1'b1 || bus.RegClockEnable !== 3'b010) begin
      errors++; $display("FAIL midrst_access: got tick=%b ce=%b want 1 010", bus.Tick, bus.RegClockEnable);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if (bus.Grant !== '0 || bus.Ack !== '0 || bus.Tick !== 1'b0 || bus.RegCs !== '1 || bus.RegClockEnable !== '0) begin
      errors++; $display("FAIL midrst_ctrl: got g=%b a=%b tick=%b cs=%b ce=%b want reset values",
                         bus.Grant, bus.Ack, bus.Tick, bus.RegCs, bus.RegClockEnable);
    end
    checks++;
    if (bus.BusWrData !== '0 || bus.RdData !== '0 || phys[1] !== init_val(1)) begin
      errors++; $display("FAIL midrst_data: got d=%h rd=%h reg1=%h want 0 0 %h",
                         bus.BusWrData, bus.RdData, phys[1], init_val(1));
    end
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (bus.Ack !== '0 || bus.Grant !== '0) begin
        errors++; $display("FAIL midrst_after%0d: got a=%b g=%b want 0", c, bus.Ack, bus.Grant);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      run_txn(NREQ'($urandom), NREQ'($urandom), AW'($urandom), DW'($urandom),
              ($urandom_range(0, 3) == 0), "random");
    end
  endtask

`ifdef REG_BUS_PRESET_EN
  task automatic test_preset();
    bus.Req = 2'b01; bus.ReqPreset = 2'b01; bus.ReqWrite = 2'b01;
    bus.ReqAddr = '0; bus.ReqData = {8'h00, 8'h42};
    step();
    bus.Req = '0; bus.ReqPreset = '0;
    step();
    checks++;
    if (bus.RegPre !== 3'b001 || bus.Tick !== 1'b0 || bus.RegClockEnable !== '0) begin
      errors++; $display("FAIL preset_access: got pre=%b tick=%b ce=%b want 001 0 000",
                         bus.RegPre, bus.Tick, bus.RegClockEnable);
    end
    step();
    checks++;
    if (bus.RegPre !== '0 || bus.Ack !== 2'b01) begin
      errors++; $display("FAIL preset_done: got pre=%b a=%b want 000 01", bus.RegPre, bus.Ack);
    end
    step();
    mem_m[0] = '1;
    ptr_m = 0;
    run_txn(2'b10, 2'b00, {2'd0, 2'd0}, '0, 1'b0, "preset_readback");
  endtask
`endif

  initial begin
    clear_inputs();
    model_reset();
    test_reset();
    test_write_basic();
    test_read_basic();
    test_out_of_range();
    test_drop_req();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef REG_BUS_PRESET_EN
    test_preset();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_bus_sequencer.md
REG_BUS_SEQUENCER -- requirements
Module: reg_bus_sequencer

Interface
REQ-001 SHALL have parameter NrOfRequesters, default 2: number of requesters sharing the register bus.
REQ-002 SHALL have parameter NrOfRegs, default 4: number of bus registers controlled.
REQ-003 SHALL have parameter NrOfBits, default 8: register data width.
REQ-004 SHALL have parameter AddrBits, default 2: register address width.
REQ-005 SHALL have port Clock  in  1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port Reset  in  1: reset, synchronous and active-low.
REQ-007 SHALL have port Req  in  NrOfRequesters: per-requester request, held until Ack.
REQ-008 SHALL have port ReqWrite  in  NrOfRequesters: per-requester op, 1 = write, 0 = read.
REQ-009 SHALL have port ReqAddr  in  NrOfRequesters*AddrBits: per-requester register address.
REQ-010 SHALL have port ReqData  in  NrOfRequesters*NrOfBits: per-requester write data.
REQ-011 SHALL have port Grant  out  NrOfRequesters: one-hot current owner, zero when idle.
REQ-012 SHALL have port Ack  out  NrOfRequesters: one-hot, one-cycle completion pulse.
REQ-013 SHALL have port RdData  out  NrOfBits: read result, valid in the Ack cycle, held until the next read completes.
REQ-014 SHALL have port BusWrData  out  NrOfBits: shared D bus to all registers.
REQ-015 SHALL have port BusRdData  in  NrOfBits: shared tristate-resolved Q bus.
REQ-016 SHALL have port RegCs  out  NrOfRegs: per-register cs; 1 = output high-Z, 0 = drives bus.
REQ-017 SHALL have ports RegClockEnable  out  NrOfRegs and Tick  out  1: per-register load enable and the shared load tick.

Function
REQ-018 SHALL implement FSM IDLE -> GRANT -> ACCESS -> DONE -> IDLE, one cycle in each non-IDLE state.
REQ-019 In IDLE with any Req high, SHALL select the winner round-robin, starting at last owner + 1 mod NrOfRequesters, and latch its op/addr/data.
REQ-020 In IDLE with no Req high, SHALL remain in IDLE.
REQ-021 Latency: request sampled at edge t -> GRANT in cycle t+1, ACCESS in t+2, Ack in t+3 (DONE), IDLE in t+4.
REQ-022 Grant SHALL be high for the owner in GRANT, ACCESS and DONE.
REQ-023 Write: in ACCESS, SHALL drive BusWrData = latched data, RegClockEnable[addr] = 1 and Tick = 1, for exactly one cycle.
REQ-024 Read: in ACCESS, SHALL drive RegCs[addr] = 0; BusRdData is sampled into RdData at the end of ACCESS.
REQ-025 At most one RegCs bit SHALL be 0 in any cycle; all RegCs = 1 outside ACCESS.
REQ-026 Tick and RegClockEnable SHALL be 0 outside a write ACCESS cycle; BusWrData SHALL hold its last value.
REQ-027 Address >= NrOfRegs: no RegCs/RegClockEnable asserted; a read returns 0; Ack still issued.
REQ-028 A Req deasserted after latching SHALL NOT abort the transaction; it completes with Ack.
REQ-029 New requests arriving in GRANT, ACCESS or DONE SHALL wait for IDLE, so there is no back-to-back grant without an IDLE cycle.
REQ-030 The round-robin pointer SHALL update to the owner in DONE.

Reset
REQ-031 With Reset low at a rising edge: FSM = IDLE, Grant = 0, Ack = 0, RdData = 0, BusWrData = 0, RegCs = all 1, RegClockEnable = 0, Tick = 0, pointer = last index (requester 0 wins first).
REQ-032 Reset mid-transaction SHALL abandon it with no Ack and no register load.

Configuration
REQ-033 With macro REG_BUS_PRESET_EN defined, SHALL add input ReqPreset (NrOfRequesters) and output RegPre (NrOfRegs).
REQ-034 Under REG_BUS_PRESET_EN, a preset request SHALL pulse RegPre[addr] for the ACCESS cycle only, and SHALL take priority over ReqWrite.
REQ-035 Without REG_BUS_PRESET_EN, the ReqPreset and RegPre ports and the preset logic SHALL be absent.

Structure
REQ-036 Package reg_bus_pkg SHALL hold the FSM state enum (IDLE, GRANT, ACCESS, DONE) and the op encoding (READ, WRITE, PRESET).
REQ-037 Round-robin selection SHALL be a sub-module rr_arbiter (req vector, pointer in; one-hot grant out).

Verification
REQ-038 Req = 01, write, addr 2, data 0xA5 -> Tick and RegClockEnable = 0100 in cycle t+2, Ack = 01 in t+3.
REQ-039 Req = 01, read, addr 1, BusRdData = 0x3C -> RegCs = 1101 in t+2, RdData = 0x3C with Ack = 01 in t+3.
REQ-040 Req = 11 held continuously from reset -> grants alternate 01, 10, 01, with each transaction 4 cycles apart.
REQ-041 Read with addr 3 when NrOfRegs = 3 -> all RegCs stay 1, RdData = 0, Ack issued.
REQ-042 Reset low during ACCESS of a write -> no Ack, all outputs at reset values at the next edge.
REQ-043 With REG_BUS_PRESET_EN, ReqPreset = 01 and ReqWrite = 01, addr 0 -> RegPre = 0001 in t+2 and Tick = 0.
